// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter: round-robin burst scheduler for the FIFO write port.
// Define FIFO_BURST_ARB_TIMEOUT_EN to abort bursts whose owner stays idle for 16 cycles.
module fifo_burst_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 32,
  parameter int ADDRWIDTH = 6,
  parameter int FIFODEPTH = 44,
  parameter int BURSTLEN  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        last,
  input  logic [NREQ*DWIDTH-1:0] din,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  input  logic                   w_full,
  input  logic [ADDRWIDTH:0]     w_counter,
  output logic                   w_en,
  output logic [DWIDTH-1:0]      w_data,
  output logic                   busy,
  output logic                   abort
);
  localparam int RW = $clog2(NREQ);
  localparam int CW = $clog2(BURSTLEN + 1);
  localparam logic [ADDRWIDTH:0] DEPTH = (ADDRWIDTH + 1)'(FIFODEPTH);
  localparam logic [ADDRWIDTH:0] BLEN  = (ADDRWIDTH + 1)'(BURSTLEN);
  typedef enum logic {IDLE, BURST} state_t;
  state_t            state_q;
  logic [RW-1:0]     rr_q, g_q, pick_d;
  logic              pick_ok_d;
  logic [CW-1:0]     cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic              busy_q;
  logic [ADDRWIDTH:0] free_d;
  logic              done_d, timeout_d;
  // A lagging w_counter only overstates occupancy, so this never over-grants.
  assign free_d = (w_counter > DEPTH) ? '0 : DEPTH - w_counter;
  always_comb begin
    pick_ok_d = 1'b0;
    pick_d    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_ok_d && req[(int'(rr_q) + k) % NREQ]) begin
        pick_ok_d = 1'b1;
        pick_d    = RW'((int'(rr_q) + k) % NREQ);
      end
    end
  end
  assign w_en   = busy_q & req[g_q] & ~w_full;
  assign w_data = din[int'(g_q)*DWIDTH +: DWIDTH];
  assign ack    = gnt_q & {NREQ{w_en}};
  assign gnt    = gnt_q;
  assign busy   = busy_q;
  assign done_d = w_en & (last[g_q] | (cnt_q == CW'(BURSTLEN - 1)));
`ifdef FIFO_BURST_ARB_TIMEOUT_EN
  logic [4:0] idle_q;
  logic       abort_q;
  assign timeout_d = busy_q & ~req[g_q] & (idle_q == 5'd15);
  assign abort     = abort_q;
`else
  assign timeout_d = 1'b0;
  assign abort     = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= RW'(NREQ - 1);
      g_q     <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
`ifdef FIFO_BURST_ARB_TIMEOUT_EN
      idle_q  <= '0;
      abort_q <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      if (pick_ok_d && free_d >= BLEN) begin
        state_q <= BURST;
        g_q     <= pick_d;
        gnt_q   <= NREQ'(1) << pick_d;
        busy_q  <= 1'b1;
      end
    end else begin
      if (w_en) cnt_q <= cnt_q + 1'b1;
`ifdef FIFO_BURST_ARB_TIMEOUT_EN
      idle_q <= req[g_q] ? '0 : idle_q + 1'b1;
      if (timeout_d) abort_q <= 1'b1;
`endif
      if (done_d || timeout_d) begin
        state_q <= IDLE;
        rr_q    <= g_q;
        gnt_q   <= '0;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
`ifdef FIFO_BURST_ARB_TIMEOUT_EN
        idle_q  <= '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// tb_fifo_burst_arbiter: directed and random stimulus against a transaction-level model.
module tb_fifo_burst_arbiter;
  localparam int N = 4, DW = 32, AW = 6, DEPTH = 44, BL = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, last = '0, gnt, ack;
  logic [N*DW-1:0] din = '0;
  logic w_full = 1'b0, w_en, busy, abort;
  logic [AW:0] w_counter = '0;
  logic [DW-1:0] w_data;
  int checks = 0, failures = 0;
  int owner, m_rr, m_cnt, m_idle;
  bit m_abort;
  int burst_acks;
  logic busy_prev;
  logic [N-1:0] gnt_prev;
  int dut_lens[$];
  logic [N-1:0] dut_grants[$];

  fifo_burst_arbiter #(.NREQ(N), .DWIDTH(DW), .ADDRWIDTH(AW), .FIFODEPTH(DEPTH), .BURSTLEN(BL)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .din(din), .gnt(gnt), .ack(ack),
    .w_full(w_full), .w_counter(w_counter), .w_en(w_en), .w_data(w_data), .busy(busy), .abort(abort));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; m_rr = N - 1; m_cnt = 0; m_idle = 0; m_abort = 0;
    burst_acks = 0; busy_prev = 1'b0; gnt_prev = '0;
  endtask

  // Advance the model across one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int free;
    bit fin;
    if (owner < 0) begin
      free = (int'(w_counter) > DEPTH) ? 0 : DEPTH - int'(w_counter);
      if (free >= BL)
        for (int k = 1; k <= N; k++)
          if (owner < 0 && req[(m_rr + k) % N]) owner = (m_rr + k) % N;
      m_cnt = 0; m_idle = 0;
    end else begin
      fin = 0;
      if (req[owner] && !w_full) begin
        m_cnt++;
        fin = last[owner] || m_cnt == BL;
      end
`ifdef FIFO_BURST_ARB_TIMEOUT_EN
      if (!req[owner]) begin
        m_idle++;
        if (m_idle == 16) begin fin = 1; m_abort = 1; end
      end else m_idle = 0;
`endif
      if (fin) begin m_rr = owner; owner = -1; end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    bit ew;
    eg = (owner >= 0) ? N'(1) << owner : '0;
    ew = owner >= 0 && req[owner] && !w_full;
    check("gnt", gnt, eg);
    check("busy", busy, owner >= 0);
    check("w_en", w_en, ew);
    check("ack", ack, ew ? eg : '0);
    if (ew) check("w_data", w_data, din[owner*DW +: DW]);
    check("abort", abort, m_abort);
    if (ack != 0) burst_acks++;
    if (busy_prev && !busy) begin dut_lens.push_back(burst_acks); burst_acks = 0; end
    if (gnt != 0 && gnt != gnt_prev) dut_grants.push_back(gnt);
    busy_prev = busy; gnt_prev = gnt;
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic f, input logic [AW:0] c);
    @(posedge clk); #1;
    if (!rst) model_edge();
    req = r; last = l; w_full = f; w_counter = c;
    for (int i = 0; i < N; i++) din[i*DW +: DW] = $urandom;
    #3;
    check_outputs();
  endtask

  // Asynchronous assertion between clock edges; outputs must clear without an edge.
  task automatic apply_reset();
    #1; rst = 1'b1; #1;
    check("rst_gnt", gnt, 0); check("rst_busy", busy, 0);
    check("rst_w_en", w_en, 0); check("rst_ack", ack, 0); check("rst_abort", abort, 0);
    model_reset();
    req = '0; last = '0; w_full = 1'b0; w_counter = '0;
    @(posedge clk); #3; rst = 1'b0;
    dut_lens.delete(); dut_grants.delete();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    apply_reset();
    // Short burst terminated by last on the third word.
    step(4'b0001, 0, 0, 0); check("t1_no_gnt_yet", gnt, 0);
    step(4'b0001, 0, 0, 0); check("t1_gnt", gnt, 4'b0001);
    step(4'b0001, 0, 0, 0);
    step(4'b0001, 4'b0001, 0, 0);
    step(4'b0000, 0, 0, 0); check("t1_busy_end", busy, 0); check("t1_gnt_end", gnt, 0);
    check("t1_len", dut_lens.size() > 0 ? dut_lens[0] : 99, 3);
    // Continuous requests: round-robin full bursts with a dead cycle between.
    apply_reset();
    repeat (46) step(4'b1111, 0, 0, 0);
    check("t2_ngrants", dut_grants.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      check($sformatf("t2_grant%0d", i), i < dut_grants.size() ? dut_grants[i] : 0, N'(1) << (i % N));
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_len%0d", i), i < dut_lens.size() ? dut_lens[i] : 99, BL);
    // Free-space threshold.
    apply_reset();
    repeat (3) begin step(4'b0010, 0, 0, 37); check("t3_no_gnt", gnt, 0); end
    step(4'b0010, 0, 0, 36); check("t3_gnt_lat", gnt, 0);
    step(4'b0010, 0, 0, 36); check("t3_gnt", gnt, 4'b0010);
    step(4'b0010, 4'b0010, 0, 36);
    step(4'b0000, 0, 0, 36);
    // Full stall mid-burst.
    apply_reset();
    step(4'b0001, 0, 0, 0);
    repeat (3) step(4'b0001, 0, 0, 0);
    repeat (5) begin step(4'b0001, 0, 1, 0); check("t4_stall_w_en", w_en, 0); check("t4_stall_ack", ack, 0); end
    repeat (8) step(4'b0001, 0, 0, 0);
    check("t4_len", dut_lens.size() > 0 ? dut_lens[0] : 99, BL);
    // Requester bubbles.
    apply_reset();
    step(4'b0001, 0, 0, 0);
    repeat (2) step(4'b0001, 0, 0, 0);
    repeat (3) begin step(4'b0000, 0, 0, 0); check("t5_bubble_busy", busy, 1); end
    repeat (8) step(4'b0001, 0, 0, 0);
    check("t5_len", dut_lens.size() > 0 ? dut_lens[0] : 99, BL);
    step(4'b0001, 0, 0, 0);
    step(4'b0000, 0, 0, 0);
    repeat (20) step(4'b0000, 0, 0, 0);
`ifdef FIFO_BURST_ARB_TIMEOUT_EN
    check("t5_timeout_busy", busy, 0); check("t5_abort", abort, 1);
`else
    check("t5_wait_busy", busy, 1); check("t5_abort", abort, 0);
`endif
    repeat (10) step(4'b0001, 4'b0001, 0, 0);
    // Reset during the fourth word, then requester 0 must win again.
    apply_reset();
    step(4'b1111, 0, 0, 0);
    repeat (4) step(4'b1111, 0, 0, 0);
    check("t6_mid_w_en", w_en, 1);
    apply_reset();
    step(4'b1111, 0, 0, 0);
    step(4'b1111, 0, 0, 0); check("t6_gnt", gnt, 4'b0001);
    // Random traffic.
    for (int n = 0; n < 900; n++) begin
      logic [N-1:0] r, l;
      if (n % 300 == 299) apply_reset();
      r = N'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) r = '0;
      l = '0;
      for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 9) == 0);
      step(r, l, $urandom_range(0, 7) == 0,
           ($urandom_range(0, 9) == 0) ? (AW+1)'($urandom_range(30, 127)) : (AW+1)'($urandom_range(0, 36)));
      check("inv_full", w_en & w_full, 0);
      check("inv_onehot", $countones(gnt) <= 1, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
